sram_rw_arbiter: RTL
====================

Name: sram_rw_arbiter

Overview:
- Shares one single-port RW SRAM macro between a read requester and a masked-write requester.
- Target macro: 4096 x 192, sixteen 12-bit write-mask lanes, registered read address, read data valid the cycle after issue.
- Issues at most one SRAM operation per cycle; reads have priority, with bounded write starvation.
- Captures read data into a hold register so consumer backpressure never loses a response. Sits between the pipeline request queues and the macro.

Parameters:
ADDR_WIDTH, 12, SRAM address width (4096 entries)
DATA_WIDTH, 192, SRAM word width
MASK_WIDTH, 16, write-mask lanes (lane = DATA_WIDTH/MASK_WIDTH = 12 bits)
STARVE_LIMIT, 4, consecutive cycles a pending write may lose arbitration before it is forced

Ports:
clock  input  1  clock for all state
reset  input  1  synchronous active-high reset
rd_req_valid  input  1  read request valid
rd_req_ready  output  1  read request accepted this cycle
rd_req_addr  input  ADDR_WIDTH  read address
rd_resp_valid  output  1  read response valid
rd_resp_ready  input  1  consumer accepts response
rd_resp_data  output  DATA_WIDTH  read response data
wr_req_valid  input  1  write request valid
wr_req_ready  output  1  write request accepted this cycle
wr_req_addr  input  ADDR_WIDTH  write address
wr_req_mask  input  MASK_WIDTH  per-lane write enable
wr_req_data  input  DATA_WIDTH  write data
sram_en  output  1  macro enable
sram_wmode  output  1  1 = write, 0 = read
sram_addr  output  ADDR_WIDTH  macro address
sram_wmask  output  MASK_WIDTH  macro lane mask
sram_wdata  output  DATA_WIDTH  macro write data
sram_rdata  input  DATA_WIDTH  macro read data, valid the cycle after a read issue

Behaviour:
- State:
  - inflight (read issued last cycle)
  - hold_valid, plus hold_data[DATA_WIDTH-1:0]
  - starve_cnt (range 0..STARVE_LIMIT)
- Read eligibility: rd_ok = rd_req_valid && !hold_valid && !(inflight && !rd_resp_ready).
- Arbitration, combinational, per cycle:
  - force_wr = wr_req_valid && starve_cnt == STARVE_LIMIT.
  - grant_wr = wr_req_valid && (force_wr || !rd_ok).
  - grant_rd = rd_ok && !grant_wr.
  - rd_req_ready = grant_rd; wr_req_ready = grant_wr.
  - Ready may depend on valid; requesters must not make valid depend on ready.
- SRAM drive:
  - sram_en = grant_rd | grant_wr; sram_wmode = grant_wr.
  - sram_addr = grant_wr ? wr_req_addr : rd_req_addr.
  - sram_wmask / sram_wdata = write fields when grant_wr, else all zeros.
- All-zero write mask: accepted and issued normally (the macro write is a no-op).
- starve_cnt:
  - Cleared on grant_wr.
  - Incremented (saturating at STARVE_LIMIT) when wr_req_valid && !grant_wr.
  - Cleared when wr_req_valid = 0.
- Read latency: read accepted in cycle T -> rd_resp_valid = 1 in T+1 with rd_resp_data = sram_rdata (bypass path).
- Response backpressure:
  - If inflight && !rd_resp_ready: hold_data <= sram_rdata and hold_valid <= 1 at the end of the cycle.
  - While hold_valid: rd_resp_valid = 1 and rd_resp_data = hold_data.
  - hold_valid clears when rd_resp_ready = 1.
  - A bypass response and a held response never coexist, because rd_ok blocks new reads while the hold is occupied or about to fill.
- Full-rate reads: with rd_resp_ready tied high, one read per cycle, one response per cycle, in order.
- Ordering: the macro is single-port, so accepted operations execute in grant order.
  - Write to A in T, read of A in T+1: response returns the new data.
  - Read of A in T, write to A in T+1: response returns the old data (captured in T+1, before the write commits).
- rd_resp_data while rd_resp_valid = 0 is don't-care; the bench must not check it.
- Reset (synchronous, any cycle):
  - inflight, hold_valid and starve_cnt clear.
  - While reset is high, sram_en, rd_req_ready, wr_req_ready and rd_resp_valid are forced to 0.
  - An in-flight or held read is dropped; no response is delivered for it.
  - hold_data is not reset.

Test Plan:
- Write A=0x005, mask 0xFFFF, data D1; then read 0x005 with rd_resp_ready=1 -> rd_resp_valid one cycle after the read grant, data = D1.
- Partial write to 0x005, mask 0x0001, data 0xABC in bits [11:0] -> read returns D1 with lane 0 replaced by 0xABC, all other lanes unchanged.
- Read valid held continuously and write valid continuously, STARVE_LIMIT=4 -> 4 read grants, then 1 write grant, repeating; no request lost and no duplicate grants.
- rd_resp_ready low for 3 cycles after a read to 0x010:
  - response stays valid with constant data; rd_req_ready stays 0;
  - a pending write still wins each cycle and may overwrite 0x010 without corrupting the held data;
  - the next read issues the cycle after ready rises.
- Back-to-back, same address: read 0x020 in T, write 0x020 (new data) in T+1 -> old data returned; reverse order (write then read) -> new data returned.
- Assert reset for one cycle in the cycle after a read grant -> no rd_resp_valid ever appears for that read; after reset, all outputs 0 and starve_cnt = 0.

Source files
------------

// File: rtl/sram_rw_arbiter.sv
// rtl/sram_rw_arbiter.sv - read-priority arbiter for one single-port RW SRAM with response hold register
module sram_rw_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 192,
    parameter int MASK_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [MASK_WIDTH-1:0] wr_req_mask,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    output logic                  sram_en,
    output logic                  sram_wmode,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [MASK_WIDTH-1:0] sram_wmask,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic                  inflight_q, inflight_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

    logic rd_ok, force_wr, grant_wr, grant_rd;

    // A read is only eligible when its response is guaranteed a slot next cycle.
    always_comb begin
        rd_ok    = rd_req_valid && !hold_valid_q && !(inflight_q && !rd_resp_ready);
        force_wr = wr_req_valid && (starve_cnt_q == CNT_MAX);
        grant_wr = !reset && wr_req_valid && (force_wr || !rd_ok);
        grant_rd = !reset && rd_ok && !grant_wr;
    end

    always_comb begin
        rd_req_ready  = grant_rd;
        wr_req_ready  = grant_wr;
        sram_en       = grant_rd | grant_wr;
        sram_wmode    = grant_wr;
        sram_addr     = grant_wr ? wr_req_addr : rd_req_addr;
        sram_wmask    = grant_wr ? wr_req_mask : '0;
        sram_wdata    = grant_wr ? wr_req_data : '0;
        rd_resp_valid = !reset && (hold_valid_q || inflight_q);
        rd_resp_data  = hold_valid_q ? hold_data_q : sram_rdata;
    end

    always_comb begin
        inflight_d   = grant_rd;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        starve_cnt_d = starve_cnt_q;

        if (hold_valid_q && rd_resp_ready) begin
            hold_valid_d = 1'b0;
        end
        // Macro output is only valid for one cycle, so a stalled response is parked here.
        if (inflight_q && !rd_resp_ready) begin
            hold_valid_d = 1'b1;
            hold_data_d  = sram_rdata;
        end

        if (grant_wr || !wr_req_valid) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        hold_data_q <= hold_data_d;
        if (reset) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
